// File: rtl/combo_lock_ctrl.sv
// Push-button combination lock sequencer: collects a fixed-length code, opens the lock for a
// bounded time, counts failed attempts and enforces a timed alarm lockout.
module combo_lock_ctrl #(
    parameter int unsigned          CODE_LEN      = 4,
    parameter logic [CODE_LEN-1:0]  CODE          = 4'b1011,
    parameter int unsigned          MAX_TRIES     = 3,
    parameter int unsigned          UNLOCK_TICKS  = 5,
    parameter int unsigned          LOCKOUT_TICKS = 10,
    parameter int unsigned          ENTRY_TIMEOUT = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       key0_i,
    input  logic       key1_i,
    input  logic       relock_i,
    output logic       unlocked_o,
    output logic       alarm_o,
    output logic [2:0] tries_left_o,
    output logic [3:0] digits_o,
    output logic       busy_o
);

    localparam int unsigned MaxOf2   = (UNLOCK_TICKS > LOCKOUT_TICKS) ? UNLOCK_TICKS
                                                                      : LOCKOUT_TICKS;
    localparam int unsigned MaxTicks = (MaxOf2 > ENTRY_TIMEOUT) ? MaxOf2 : ENTRY_TIMEOUT;
    localparam int unsigned TimerW   = $clog2(MaxTicks + 1);

    typedef enum logic [1:0] {StEntry, StCheck, StOpen, StLockout} state_e;

    state_e              state_q, state_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [3:0]          digits_q, digits_d;
    logic [TimerW-1:0]   timer_q, timer_d, timer_inc;
    logic [2:0]          tries_q, tries_d;
    logic                unlocked_q, unlocked_d;
    logic                alarm_q, alarm_d;
    logic                busy_q, busy_d;
    logic                key_one;
    logic                code_ok;

    // A simultaneous key0+key1 is one ambiguous press and is thrown away.
    assign key_one   = key0_i ^ key1_i;
    assign code_ok   = (shift_q == CODE);
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StEntry;
            shift_q    <= '0;
            digits_q   <= '0;
            timer_q    <= '0;
            tries_q    <= 3'(MAX_TRIES);
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            digits_q   <= digits_d;
            timer_q    <= timer_d;
            tries_q    <= tries_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEntry: begin
                if (key_one && (digits_q == 4'(CODE_LEN - 1))) state_d = StCheck;
            end
            StCheck: begin
                if (code_ok)               state_d = StOpen;
                else if (tries_q > 3'd1)   state_d = StEntry;
                else                       state_d = StLockout;
            end
            StOpen: begin
                if (relock_i || (tick_i && (timer_q == TimerW'(UNLOCK_TICKS - 1)))) begin
                    state_d = StEntry;
                end
            end
            StLockout: begin
                if (tick_i && (timer_q == TimerW'(LOCKOUT_TICKS - 1))) state_d = StEntry;
            end
            default: state_d = StEntry;
        endcase
    end

    always_comb begin
        shift_d  = shift_q;
        digits_d = digits_q;
        timer_d  = timer_q;
        tries_d  = tries_q;
        unique case (state_q)
            StEntry: begin
                // A real press beats a timeout landing in the same cycle.
                if (key_one) begin
                    shift_d  = (shift_q << 1) | CODE_LEN'(key1_i);
                    digits_d = digits_q + 4'd1;
                    timer_d  = '0;
                end else if (tick_i && (digits_q != 4'd0)) begin
                    if (timer_q == TimerW'(ENTRY_TIMEOUT - 1)) begin
                        shift_d  = '0;
                        digits_d = '0;
                        timer_d  = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            StCheck: begin
                shift_d  = '0;
                digits_d = '0;
                timer_d  = '0;
                tries_d  = code_ok ? 3'(MAX_TRIES) : tries_q - 3'd1;
            end
            StOpen: begin
                if (tick_i) timer_d = timer_inc;
                if (state_d == StEntry) timer_d = '0;
            end
            StLockout: begin
                if (tick_i) timer_d = timer_inc;
                if (state_d == StEntry) begin
                    timer_d = '0;
                    tries_d = 3'(MAX_TRIES);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        unlocked_d = (state_d == StOpen);
        alarm_d    = (state_d == StLockout);
        busy_d     = (state_d != StEntry);
    end

    assign unlocked_o   = unlocked_q;
    assign alarm_o      = alarm_q;
    assign busy_o       = busy_q;
    assign tries_left_o = tries_q;
    assign digits_o     = digits_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Self-checking bench for combo_lock_ctrl: directed scenarios plus randomized traffic, all
// compared against an attempt/phase-level reference model.
module tb_combo_lock_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0, tick = 1'b0, key0 = 1'b0, key1 = 1'b0, relock = 1'b0;
    logic       unlocked, alarm, busy;
    logic [2:0] tries_left;
    logic [3:0] digits;

    int errors = 0;
    int checks = 0;

    // Reference model: phase 0=entering, 1=judging, 2=open, 3=alarm.
    int m_phase, m_code, m_presses, m_ticks, m_tries;

    combo_lock_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tick_i      (tick),
        .key0_i      (key0),
        .key1_i      (key1),
        .relock_i    (relock),
        .unlocked_o  (unlocked),
        .alarm_o     (alarm),
        .tries_left_o(tries_left),
        .digits_o    (digits),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] dut_vec();
        return {unlocked, alarm, busy, tries_left, digits};
    endfunction

    function automatic logic [9:0] exp_vec();
        return {m_phase == 2, m_phase == 3, m_phase != 0, 3'(m_tries), 4'(m_presses)};
    endfunction

    task automatic model_step(input bit r, input bit k0, input bit k1, input bit rl, input bit tk);
        if (r) begin
            m_phase = 0; m_code = 0; m_presses = 0; m_ticks = 0; m_tries = 3;
            return;
        end
        case (m_phase)
            0: begin
                if (k0 != k1) begin
                    m_code = m_code * 2 + int'(k1);
                    m_presses++;
                    m_ticks = 0;
                    if (m_presses == 4) m_phase = 1;
                end else if (tk && m_presses > 0) begin
                    m_ticks++;
                    if (m_ticks == 8) begin m_presses = 0; m_code = 0; m_ticks = 0; end
                end
            end
            1: begin
                m_presses = 0;
                m_ticks = 0;
                if (m_code == 11) begin m_phase = 2; m_tries = 3; end
                else if (m_tries > 1) begin m_tries--; m_phase = 0; end
                else begin m_tries = 0; m_phase = 3; end
                m_code = 0;
            end
            2: begin
                if (tk) m_ticks++;
                if (rl || m_ticks == 5) begin m_phase = 0; m_ticks = 0; end
            end
            default: begin
                if (tk) m_ticks++;
                if (m_ticks == 10) begin m_phase = 0; m_ticks = 0; m_tries = 3; end
            end
        endcase
    endtask

    task automatic cycle(input bit r, input bit k0, input bit k1, input bit rl, input bit tk);
        rst = r; key0 = k0; key1 = k1; relock = rl; tick = tk;
        @(posedge clk);
        model_step(r, k0, k1, rl, tk);
        #1;
        rst = 1'b0; key0 = 1'b0; key1 = 1'b0; relock = 1'b0; tick = 1'b0;
    endtask

    task automatic enter_code(input logic [3:0] c);
        for (int i = 0; i < 4; i++) begin
            cycle(0, !c[3-i], c[3-i], 0, 0);
            if (i < 3) cycle(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 10'b0000110000) begin
            errors++; $display("FAIL reset_values: got %b want %b", dut_vec(), 10'b0000110000);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_model: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_correct_code();
        logic [3:0] c;
        c = 4'b1011;
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, !c[3-i], c[3-i], 0, 0);
            checks++;
            if (digits !== 4'(i + 1)) begin
                errors++; $display("FAIL correct_digits[%0d]: got %0d want %0d", i, digits, i + 1);
            end
            if (i < 3) cycle(0, 0, 0, 0, 0);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL check_busy: got %b want 1", busy); end
        cycle(0, 0, 0, 0, 0);
        checks++;
        if ({unlocked, digits, tries_left} !== {1'b1, 4'd0, 3'd3}) begin
            errors++;
            $display("FAIL correct_open: got u=%b d=%0d t=%0d want u=1 d=0 t=3",
                     unlocked, digits, tries_left);
        end
        for (int t = 0; t < 5; t++) begin
            cycle(0, 0, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL open_tick[%0d]: got %b want %b", t, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({unlocked, busy} !== 2'b00) begin
            errors++; $display("FAIL open_close: got u=%b b=%b want 0 0", unlocked, busy);
        end
    endtask

    task automatic test_wrong_codes();
        cycle(1, 0, 0, 0, 0);
        for (int a = 0; a < 3; a++) begin
            enter_code(4'b0000);
            cycle(0, 0, 0, 0, 0);
            checks++;
            if (tries_left !== 3'(2 - a) || alarm !== (a == 2)) begin
                errors++;
                $display("FAIL wrong_attempt[%0d]: got t=%0d a=%b want t=%0d a=%b",
                         a, tries_left, alarm, 2 - a, a == 2);
            end
        end
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        checks++;
        if (digits !== 4'd0) begin
            errors++; $display("FAIL lockout_keys: got d=%0d want 0", digits);
        end
        for (int t = 0; t < 10; t++) begin
            cycle(0, 0, 0, 0, 1);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL lockout_tick[%0d]: got %b want %b", t, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({alarm, busy, tries_left} !== {1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL lockout_end: got a=%b b=%b t=%0d want 0 0 3", alarm, busy, tries_left);
        end
    endtask

    task automatic test_simultaneous();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (digits !== 4'd0) begin errors++; $display("FAIL double_press: got d=%0d want 0", digits); end
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        checks++;
        if (digits !== 4'd1) begin errors++; $display("FAIL double_mid: got d=%0d want 1", digits); end
        cycle(0, 0, 0, 0, 0);
        enter_code(4'b1011);
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL double_then_code: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_relock();
        cycle(1, 0, 0, 0, 0);
        enter_code(4'b1011);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (unlocked !== 1'b1) begin errors++; $display("FAIL relock_pre: got u=%b want 1", unlocked); end
        cycle(0, 0, 0, 1, 1);
        checks++;
        if ({unlocked, busy} !== 2'b00) begin
            errors++; $display("FAIL relock: got u=%b b=%b want 0 0", unlocked, busy);
        end
        enter_code(4'b1011);
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (unlocked !== 1'b1) begin errors++; $display("FAIL relock_reopen: got u=%b want 1", unlocked); end
    endtask

    task automatic test_timeout();
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        for (int t = 0; t < 8; t++) begin
            cycle(0, 0, 0, 0, 1);
            checks++;
            if (digits !== ((t < 7) ? 4'd2 : 4'd0) || tries_left !== 3'd3) begin
                errors++;
                $display("FAIL timeout_tick[%0d]: got d=%0d t=%0d want d=%0d t=3",
                         t, digits, tries_left, (t < 7) ? 2 : 0);
            end
        end
        enter_code(4'b1011);
        cycle(0, 0, 0, 0, 0);
        checks++;
        if (unlocked !== 1'b1) begin errors++; $display("FAIL timeout_code: got u=%b want 1", unlocked); end
    endtask

    task automatic test_reset_mid();
        cycle(1, 0, 0, 0, 0);
        enter_code(4'b1011);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 10'b0000110000) begin
            errors++; $display("FAIL reset_in_open: got %b want %b", dut_vec(), 10'b0000110000);
        end
        for (int a = 0; a < 3; a++) begin
            enter_code(4'b0110);
            cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (alarm !== 1'b1) begin errors++; $display("FAIL reset_pre_lockout: got a=%b want 1", alarm); end
        cycle(1, 0, 0, 0, 0);
        checks++;
        if (dut_vec() !== 10'b0000110000) begin
            errors++; $display("FAIL reset_in_lockout: got %b want %b", dut_vec(), 10'b0000110000);
        end
    endtask

    task automatic test_random();
        bit r, k0, k1, rl, tk;
        cycle(1, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(0, 299) == 0);
            k0 = ($urandom_range(0, 3) == 0);
            k1 = ($urandom_range(0, 3) == 0);
            rl = ($urandom_range(0, 15) == 0);
            tk = ($urandom_range(0, 3) == 0);
            cycle(r, k0, k1, rl, tk);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %b want %b", n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        m_phase = 0; m_code = 0; m_presses = 0; m_ticks = 0; m_tries = 3;
        #1;
        test_reset();
        test_correct_code();
        test_wrong_codes();
        test_simultaneous();
        test_relock();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the on/off push-button lock. Consumes single-cycle button pulses from the level-to-pulse stages and a slow tick from the clock divider. Checks a fixed-length button code, drives the unlock output for a bounded time, counts failed attempts, and enforces an alarm lockout after repeated failures. Sits between the button pulse generators and the lock actuator and indicator LEDs.

## Interface
- CODE_LEN, 4: button presses per code attempt (1..8).
- CODE, 4'b1011: expected code. The first press lands in the MSB; a key1 press is 1 and a key0 press is 0.
- MAX_TRIES, 3: failed attempts allowed before lockout (1..7).
- UNLOCK_TICKS, 5: ticks the lock stays open (≥1).
- LOCKOUT_TICKS, 10: ticks of alarm lockout (≥1).
- ENTRY_TIMEOUT, 8: idle ticks after which a partial entry is discarded (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle enable from the clock divider; time base for all timers.
- key0  in  1  one-cycle pulse from the "off" button pulse stage; enters a 0.
- key1  in  1  one-cycle pulse from the "on" button pulse stage; enters a 1.
- relock  in  1  one-cycle pulse; closes the lock early.
- unlocked  out  1  lock open.
- alarm  out  1  lockout active.
- tries_left  out  3  remaining attempts.
- digits  out  4  presses accepted in the current attempt.
- busy  out  1  high in CHECK, OPEN or LOCKOUT, when keys are ignored.

## Operation
- **Outputs:** all registered. Reset values: unlocked=0, alarm=0, busy=0, tries_left=MAX_TRIES, digits=0, state=ENTRY, shift register=0, timer=0.
- **ENTRY state:**
  - A key0 or key1 pulse shifts the bit into the CODE_LEN-bit shift register, increments digits, and clears the timer.
  - key0 and key1 in the same cycle count as one press; it is discarded and no digit is added.
  - When the CODE_LEN-th press is accepted, go to CHECK.
  - While digits>0, each tick increments the timer. When the timer reaches ENTRY_TIMEOUT, clear digits, the shift register and the timer. tries_left is unchanged.
- **CHECK state (exactly 1 cycle):** clear digits.
  - On a match: go to OPEN, set unlocked=1, tries_left=MAX_TRIES, timer=0.
  - On a mismatch with tries_left>1: decrement tries_left and go to ENTRY.
  - On a mismatch with tries_left==1: set tries_left=0, go to LOCKOUT, set alarm=1, timer=0.
- **OPEN state:** each tick increments the timer. Leave on the edge after the UNLOCK_TICKS-th tick, or on relock, whichever comes first. On leaving: unlocked=0 and go to ENTRY.
- **LOCKOUT state:** each tick increments the timer. Leave on the edge after the LOCKOUT_TICKS-th tick. On leaving: alarm=0, tries_left=MAX_TRIES, go to ENTRY.
- **Ignored inputs:**
  - key0 and key1 are ignored in CHECK, OPEN and LOCKOUT, with no buffering.
  - relock is ignored outside OPEN.
- **Simultaneous events:**
  - relock and tick in the same OPEN cycle: leave once.
  - A key and the entry timeout in the same cycle: the key wins, the timer clears and the digit is accepted.
- **Mid-operation reset:** rst overrides everything. All outputs return to their reset values on the next edge, including from OPEN and LOCKOUT.
- **Counter widths:**
  - The timer width is sized for the largest of the three *_TICKS parameters.
  - The timer saturates and never wraps.

## Timing
- Key pulse at cycle N: digits updates at N+1.
- Final key at cycle N: state=CHECK at N+1. At N+2, either unlocked=1 or the tries_left decrement / alarm=1 is visible.
- **Open duration:** unlocked stays high from the CHECK exit edge through the edge following the UNLOCK_TICKS-th tick. relock at cycle M gives unlocked=0 at M+1.
- **busy:**
  - busy=1 at N+1 (CHECK).
  - After a mismatch that returns to ENTRY, busy=0 at N+2.
  - Otherwise busy stays 1 through OPEN or LOCKOUT and clears on the same edge as unlocked or alarm.
- Keys arriving in the cycle CHECK is entered, or later until the exit edge, are dropped.
- There is no combinational path from any input to any output.

## Test plan
- **Correct code:** rst, then key1, key0, key1, key1 at spaced cycles, then 5 ticks.
  - Required: digits steps 1..4 then 0.
  - unlocked=1 two cycles after the last key and 0 the cycle after the 5th tick.
  - tries_left stays 3.
- **Three wrong codes:** enter 0000 three times, then 10 ticks.
  - Required: tries_left goes 2, then 1, then 0.
  - alarm=1 after the third attempt; keys during the lockout leave digits=0.
  - After the 10th tick: alarm=0, tries_left=3.
- **Simultaneous keys:** key0 and key1 asserted in the same cycle, then a correct code.
  - Required: digits unchanged by the double press; the code still unlocks.
- **Early relock:** unlock, 2 ticks, then a relock pulse.
  - Required: unlocked=0 next cycle; a fresh correct entry reopens the lock.
- **Entry timeout:** key1, key0, then 8 ticks with no keys.
  - Required: digits=0 and tries_left=3.
  - A following correct 4-press code unlocks.
- **Reset mid-operation:** assert rst during OPEN and again during LOCKOUT.
  - Required: next edge shows unlocked=0, alarm=0, busy=0, tries_left=3, digits=0.
